// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
//   ps2_state_t   : deframer states
//   PS2_DATA_BITS : payload bits per PS/2 frame
//   PS2_BREAK / PS2_EXTEND : common scancode prefixes for downstream decoders
package ps2_pkg;

  localparam int PS2_DATA_BITS = 8;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXTEND = 8'hE0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

endpackage

// File: rtl/kbd_scan_fifo.sv
// Synchronous scancode FIFO with a show-ahead head.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   push, push_data     : write request and payload
//   pop                 : remove head entry (ignored when empty)
//   head                : current head entry, zero when empty
//   full, empty, count  : occupancy status
//   dropped             : push request rejected because the FIFO was full
module kbd_scan_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign dropped = push & ~do_push;
  assign count   = cnt;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes the raw pins, deframes 11-bit frames
// (start, 8 data LSB-first, odd parity, stop) and queues good scancodes.
// Ports:
//   CLK_CPU, resetp               : clock, synchronous active-high reset
//   keyboard_clock, keyboard_data : raw asynchronous PS/2 pins
//   rd_en, rd_data, rd_valid      : show-ahead read port
//   fifo_count                    : entries held
//   err_clr                       : clear sticky error flags
//   parity_err, frame_err, overflow_err : sticky error flags
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a clock fall)
// DATA   | shifting in the 8 payload bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit and queueing the byte
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                            CLK_CPU,
  input  logic                            resetp,
  input  logic                            keyboard_clock,
  input  logic                            keyboard_data,
  input  logic                            rd_en,
  output logic [7:0]                      rd_data,
  output logic                            rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  input  logic                            err_clr,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow_err
);

  localparam int TW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BCW = $clog2(PS2_DATA_BITS);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(PS2_DATA_BITS - 1);

  logic clk_s1, clk_s2, clk_hist;
  logic dat_s1, dat_s2;
  logic fall;

  ps2_state_t                 state, state_n;
  logic [BCW-1:0]             bit_cnt, bit_cnt_n;
  logic [PS2_DATA_BITS-1:0]   shift, shift_n;
  logic                       par_ok, par_ok_n;
  logic [TW-1:0]              tmo_cnt;
  logic                       timeout;
  logic                       push;
  logic                       set_par;
  logic                       set_frm;
  logic                       fifo_dropped;
  logic                       fifo_full;
  logic                       fifo_empty;

  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_hist <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= keyboard_clock;
      clk_s2   <= clk_s1;
      clk_hist <= clk_s2;
      dat_s1   <= keyboard_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall    = clk_hist & ~clk_s2;
  assign timeout = (state != IDLE) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      tmo_cnt <= '0;
    end else if (fall || state == IDLE) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_LAST) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par_ok  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      par_ok  <= par_ok_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_ok_n  = par_ok;
    push      = 1'b0;
    set_par   = 1'b0;
    set_frm   = 1'b0;
    // A clock fall always takes priority over an expiring timeout.
    if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_n   = DATA;
            bit_cnt_n = '0;
            shift_n   = '0;
          end
        end
        DATA: begin
          shift_n   = {dat_s2, shift[PS2_DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) state_n = PARITY;
        end
        PARITY: begin
          par_ok_n = ^{shift, dat_s2};
          state_n  = STOP;
        end
        STOP: begin
          if (dat_s2 && par_ok) push    = 1'b1;
          else if (dat_s2)      set_par = 1'b1;
          else                  set_frm = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (timeout) begin
      state_n = IDLE;
      shift_n = '0;
      set_frm = 1'b1;
    end
  end

  kbd_scan_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_DATA_BITS)
  ) u_fifo (
    .clk       (CLK_CPU),
    .reset     (resetp),
    .push      (push),
    .push_data (shift),
    .pop       (rd_en),
    .head      (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .dropped   (fifo_dropped)
  );

  assign rd_valid = ~fifo_empty;

  // Set events win over a simultaneous clear.
  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      parity_err   <= set_par      | (parity_err   & ~err_clr);
      frame_err    <= set_frm      | (frame_err    & ~err_clr);
      overflow_err <= fifo_dropped | (overflow_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed PS/2 frames, an
// expected-scancode queue filled by the stimulus, and a monitor that pops and
// compares on every accepted read.
module tb_ps2_keyboard_rx;

  logic       CLK_CPU = 1'b0;
  logic       resetp  = 1'b1;
  logic       kb_clk  = 1'b1;
  logic       kb_dat  = 1'b1;
  logic       rd_en   = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] fifo_count;
  logic       parity_err, frame_err, overflow_err;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];

  ps2_keyboard_rx #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(1000)) dut (
    .CLK_CPU        (CLK_CPU),
    .resetp         (resetp),
    .keyboard_clock (kb_clk),
    .keyboard_data  (kb_dat),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .fifo_count     (fifo_count),
    .err_clr        (err_clr),
    .parity_err     (parity_err),
    .frame_err      (frame_err),
    .overflow_err   (overflow_err)
  );

  always #5 CLK_CPU = ~CLK_CPU;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Monitor: every read the DUT accepts must match the head of the queue.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge CLK_CPU);
      #1;
      if (rd_en && rd_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rd_pop: got 0x%02h with nothing expected", rd_data);
        end else begin
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            fails++;
            $display("FAIL rd_pop: got 0x%02h expected 0x%02h", rd_data, e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One PS/2 bit period of 40 CLK_CPU cycles (12.5 kHz at 500 kHz).
  // With pop_at_fall, rd_en is high in exactly the cycle the fall is acted on.
  task automatic ps2_bit(input logic d, input bit pop_at_fall = 1'b0);
    kb_dat = d;
    repeat (10) @(negedge CLK_CPU);
    kb_clk = 1'b0;
    if (pop_at_fall) begin
      @(negedge CLK_CPU);
      @(negedge CLK_CPU);
      rd_en = 1'b1;
      @(negedge CLK_CPU);
      rd_en = 1'b0;
      repeat (17) @(negedge CLK_CPU);
    end else begin
      repeat (20) @(negedge CLK_CPU);
    end
    kb_clk = 1'b1;
    repeat (10) @(negedge CLK_CPU);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input bit expect_push, input bit pop_at_stop = 1'b0);
    if (expect_push) exp_q.push_back(b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stop, pop_at_stop);
  endtask

  task automatic read_one();
    rd_en = 1'b1;
    @(negedge CLK_CPU);
    rd_en = 1'b0;
    @(negedge CLK_CPU);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge CLK_CPU);
    err_clr = 1'b0;
    @(negedge CLK_CPU);
  endtask

  initial begin
    logic [7:0] b;

    // Reset state
    repeat (4) @(negedge CLK_CPU);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_errs", {parity_err, frame_err, overflow_err}, 0);
    resetp = 1'b0;
    @(negedge CLK_CPU);

    // Good frame 0x1C (three ones -> parity 0)
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    check("t1_valid", rd_valid, 1);
    check("t1_data", rd_data, 8'h1C);
    check("t1_count", fifo_count, 1);
    check("t1_errs", {parity_err, frame_err, overflow_err}, 0);
    read_one();
    check("t1_valid_after_rd", rd_valid, 0);
    check("t1_count_after_rd", fifo_count, 0);

    // Bad parity
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check("t2_count", fifo_count, 0);
    check("t2_parity_err", parity_err, 1);
    check("t2_frame_err", frame_err, 0);
    pulse_clr();
    check("t2_parity_clr", parity_err, 0);

    // Overflow: nine frames, only eight fit
    for (int i = 1; i <= 9; i++) begin
      b = 8'(i);
      send_frame(b, ~^b, 1'b1, i <= 8);
    end
    check("t3_count_full", fifo_count, 8);
    check("t3_overflow", overflow_err, 1);
    for (int i = 0; i < 8; i++) read_one();
    check("t3_count_drained", fifo_count, 0);
    read_one();
    check("t3_count_empty_rd", fifo_count, 0);
    check("t3_valid_empty_rd", rd_valid, 0);
    pulse_clr();
    check("t3_overflow_clr", overflow_err, 0);

    // Timeout mid-frame: start + 3 data bits then silence
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    repeat (880) @(negedge CLK_CPU);
    check("t4_frame_err_early", frame_err, 0);
    repeat (150) @(negedge CLK_CPU);
    check("t4_frame_err", frame_err, 1);
    check("t4_count", fifo_count, 0);
    send_frame(8'hF0, 1'b1, 1'b1, 1'b1);
    check("t4_data_f0", rd_data, 8'hF0);
    check("t4_count_f0", fifo_count, 1);
    read_one();
    pulse_clr();
    check("t4_frame_clr", frame_err, 0);

    // Full FIFO with a pop in the push cycle
    for (int i = 0; i < 8; i++) begin
      b = 8'h21 + 8'(i);
      send_frame(b, ~^b, 1'b1, 1'b1);
    end
    check("t5_count_full", fifo_count, 8);
    b = 8'h29;
    send_frame(b, ~^b, 1'b1, 1'b1, 1'b1);
    check("t5_count_same", fifo_count, 8);
    check("t5_overflow", overflow_err, 0);
    for (int i = 0; i < 8; i++) read_one();
    check("t5_count_drained", fifo_count, 0);

    // Bad stop bit
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    check("t6_frame_err", frame_err, 1);
    check("t6_parity_err", parity_err, 0);
    check("t6_count", fifo_count, 0);

    // Reset mid-frame after four data bits
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    resetp = 1'b1;
    repeat (2) @(negedge CLK_CPU);
    resetp = 1'b0;
    @(negedge CLK_CPU);
    check("t7_rst_count", fifo_count, 0);
    check("t7_rst_errs", {parity_err, frame_err, overflow_err}, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    check("t7_count", fifo_count, 1);
    check("t7_data", rd_data, 8'h1C);
    check("t7_errs", {parity_err, frame_err, overflow_err}, 0);
    read_one();
    check("t7_count_after_rd", fifo_count, 0);

    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
PS/2 keyboard receiver feeding the CPU's keyboard input path.
- Samples the raw keyboard_clock/keyboard_data pins in the CLK_CPU domain and deframes 11-bit PS/2 frames: start, 8 data LSB-first, odd parity, stop.
- Validated scancodes are buffered in a small FIFO that the CPU drains through a show-ahead read port.
- Sticky error flags report parity, framing/timeout and overflow faults.

Parameters:
FIFO_DEPTH, 8, scancode FIFO entries; power of two, >= 2.
TIMEOUT_CYCLES, 1000, CLK_CPU cycles without a PS/2 falling edge before a partial frame is abandoned (2 ms at 500 kHz).

Ports:
CLK_CPU  in  1  block clock; all logic on rising edge.
resetp  in  1  synchronous, active-high reset.
keyboard_clock  in  1  raw PS/2 clock pin, asynchronous.
keyboard_data  in  1  raw PS/2 data pin, asynchronous.
rd_en  in  1  pop head entry; ignored when FIFO empty.
rd_data  out  8  head scancode, show-ahead; 0x00 when empty.
rd_valid  out  1  FIFO not empty.
fifo_count  out  $clog2(FIFO_DEPTH+1)  entries held.
err_clr  in  1  clears all sticky error flags.
parity_err  out  1  sticky: frame received with bad parity.
frame_err  out  1  sticky: bad stop bit or timeout mid-frame.
overflow_err  out  1  sticky: good frame dropped because FIFO full.

Behaviour:
- Clock and reset: one clock, CLK_CPU. Reset is synchronous and active-high on resetp.
- Reset values: all outputs 0. FIFO empty. State IDLE. Synchronizer and edge-history flops = 1.
- Synchronizer: 2-flop sync on each pin, plus one history flop on the clock path.
- Edge detect: fall = hist & ~sync_clk. Data is sampled from sync_data in the same cycle as fall.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions occur only on fall, except timeout.
  - IDLE: on fall with data=0, go to DATA, bit_cnt=0. On fall with data=1, stay in IDLE; no error.
  - DATA: shift right, new bit enters bit 7. After the 8th bit (bit_cnt=7), go to PARITY.
  - PARITY: par_ok = ^{shift,data} == 1. Go to STOP.
  - STOP: data=1 and par_ok: push shift. data=1 and !par_ok: set parity_err, no push. data=0: set frame_err, no push (par_ok ignored). Always return to IDLE.
- Timeout counter:
  - Cleared on every fall and while in IDLE; otherwise increments, saturating.
  - When it reaches TIMEOUT_CYCLES-1 outside IDLE: go to IDLE, discard the partial byte, set frame_err.
  - If fall and timeout coincide, fall wins.
- Latency: 2 cycles from pin falling edge to fall. The pushed byte appears on rd_data/rd_valid/fifo_count in the cycle after the stop-bit fall.
- FIFO:
  - Circular buffer with read/write pointers of width $clog2(FIFO_DEPTH); pointers wrap naturally.
  - Pop happens on rd_en & rd_valid; rd_data shows the next entry the following cycle.
  - Push when not full. When full, the byte is dropped and overflow_err is set.
  - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: push only; the pop is ignored.
- Sticky flags: err_clr clears them. A set event in the same cycle as err_clr wins (flag stays 1).
- Reset mid-frame or with FIFO non-empty: everything returns to reset values within that cycle; no partial byte survives.

Decomposition:
- Package ps2_pkg:
  - ps2_state_t enum (IDLE, DATA, PARITY, STOP).
  - PS2_DATA_BITS=8.
  - Common scancode constants PS2_BREAK=8'hF0 and PS2_EXTEND=8'hE0, for downstream use.
- Sub-module kbd_scan_fifo: parameterized sync FIFO (push, pop, full, empty, count, show-ahead head).
- Deframer FSM, synchronizer and timeout stay in ps2_keyboard_rx.

Test Plan:
- Reset release, then frame 0x1C with parity=0 and stop=1 at 12.5 kHz -> rd_valid=1, rd_data=0x1C, fifo_count=1, all err flags 0. Pulse rd_en -> rd_valid=0, count=0.
- Frame 0x1C with parity=1 -> no push, fifo_count=0, parity_err=1. err_clr pulse -> parity_err=0.
- 9 valid frames 0x01..0x09, no reads -> fifo_count=8, overflow_err=1. Reads return 0x01..0x08 in order; a further read with empty FIFO is ignored, count stays 0.
- Start bit + 3 data bits, then hold clock high 1000 cycles -> state IDLE, frame_err=1, count=0. Then send frame 0xF0 with parity=1 -> rd_data=0xF0.
- FIFO full with rd_en held during the cycle the 9th frame pushes -> count stays 8, overflow_err=0, last entry = new byte.
- Frame 0x55 with stop=0 -> frame_err=1, no push. Then assert resetp mid-frame (after 4 data bits), release, send 0x1C -> only 0x1C received, flags 0.
